// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush/halt controller for the 5-stage WISC pipeline with a memory-wait watchdog.
// Optional saturating performance counters are enabled by defining STALL_PERF_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_en,
  input  logic mem_busy,
  input  logic branch_taken,
  input  logic halt_dec,
  input  logic halt_wb,
  output logic pc_we,
  output logic if_id_we,
  output logic if_id_flush,
  output logic id_ex_we,
  output logic id_ex_bubble,
  output logic ex_mem_we,
  output logic mem_wb_we,
  output logic halted,
  output logic mem_err
`ifdef STALL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;

  // Enables and next-state decode; memory freeze outranks every pipeline request.
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = ST_RUN;
      wait_d       = {CNT_W{1'b0}};
      err_d        = 1'b0;
    end else if (state_q == ST_HALTED) begin
      state_d = ST_HALTED;
    end else if (mem_busy) begin
      if (wait_q == TIMEOUT_C) begin
        err_d = 1'b1;
      end else begin
        wait_d = wait_q + ONE_C;
      end
    end else begin
      wait_d = {CNT_W{1'b0}};
      case (state_q)
        ST_RUN: begin
          if (stall_en) begin
            // Branch operands are not ready yet, so a concurrent branch_taken is ignored.
            id_ex_we     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_we    = 1'b1;
            mem_wb_we    = 1'b1;
          end else if (halt_dec) begin
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            state_d     = ST_DRAIN;
          end else if (branch_taken) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
          end
          if (halt_wb) begin
            state_d = ST_HALTED;
          end else begin
            state_d = state_d;
          end
        end
        ST_DRAIN: begin
          if_id_we     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_we     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
          if (halt_wb) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
    halted_d = (state_d == ST_HALTED);
  end

  // Controller state, watchdog and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      wait_q   <= {CNT_W{1'b0}};
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign halted  = halted_q;
  assign mem_err = err_q;

`ifdef STALL_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + ONE_C;
    end else begin
      sat_inc = v;
    end
  endfunction

  logic             stall_evt_s, flush_evt_s, freeze_evt_s;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  assign stall_evt_s  = !rst && (state_q == ST_RUN) && !mem_busy && stall_en;
  assign flush_evt_s  = !rst && if_id_we && if_id_flush;
  assign freeze_evt_s = !rst && (state_q != ST_HALTED) && mem_busy;

  // Saturating event counters; no events occur in HALTED so they stay frozen there.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= {CNT_W{1'b0}};
      flush_cnt_q   <= {CNT_W{1'b0}};
      memwait_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q   <= sat_inc(stall_cnt_q, stall_evt_s);
      flush_cnt_q   <= sat_inc(flush_cnt_q, flush_evt_s);
      memwait_cnt_q <= sat_inc(memwait_cnt_q, freeze_evt_s);
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`endif

endmodule
